key_expansion: RTL and testbench
================================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter: KEY_W, 128, cipher key and round key width; only 128 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port: rst1  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to expand key_in.
REQ-005 SHALL have port: key_in  input  128  AES-128 cipher key; w0 = key_in[127:96].
REQ-006 SHALL have port: busy  output  1  expansion in progress.
REQ-007 SHALL have port: rk_valid  output  1  rk_data/rk_idx hold a valid round key this cycle.
REQ-008 SHALL have port: rk_idx  output  4  round key index, 0..10.
REQ-009 SHALL have port: rk_data  output  128  round key for rk_idx.
REQ-010 SHALL have port: keys_ready  output  1  level; all 11 round keys produced.
REQ-011 SHALL have port: rd_idx  input  4  key store read index.
REQ-012 SHALL have port: rd_key  output  128  combinational key store read data.

Function
- REQ-013 SHALL use states IDLE, EXPAND, DONE.
  - IDLE->EXPAND on start.
  - EXPAND->DONE after index 10.
  - DONE->EXPAND on start.
- REQ-014 SHALL accept start only in IDLE or DONE and latch key_in that cycle; start while busy SHALL be ignored.
- REQ-015 SHALL, when start is accepted in cycle T:
  - present rk_idx=0, rk_data=key_in at T+1;
  - present index n at T+1+n, one per cycle with no bubbles;
  - present index 10 at T+11.
- REQ-016 SHALL compute each key from the previous one:
  - temp = SubWord(RotWord(w3)) ^ {Rcon[n],24'h0}.
  - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- REQ-017 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- REQ-018 SHALL have busy high from T+1 through T+11 inclusive.
- REQ-019 SHALL have rk_valid high exactly in cycles T+1..T+11.
- REQ-020 SHALL raise keys_ready at T+12 and hold it until the next accepted start, which SHALL clear it at the next edge.
- REQ-021 SHALL treat start asserted in the same cycle as index 10 as busy and ignore it.
- REQ-022 SHALL hold rk_data and rk_idx at their last values when rk_valid is low.

Reset
- REQ-023 SHALL, while rst1 is high, immediately force:
  - state=IDLE, busy=0, rk_valid=0, keys_ready=0;
  - rk_idx=0, rk_data=0, and all key store entries to 0.
- REQ-024 SHALL, on reset asserted mid-expansion, abort it with no further rk_valid.
- REQ-025 SHALL ignore start while rst1 is high; the first accepted start is in the first cycle after deassertion.

Configuration
- REQ-026 SHALL, with KEY_STORE_EN defined:
  - keep an 11x128 store written as each rk_valid key is produced;
  - set rd_key = store[rd_idx] when rd_idx<=10, else 0.
- REQ-027 SHALL, without KEY_STORE_EN, contain no key store and tie rd_key to 0; the streamed outputs SHALL be unchanged.

Structure
- REQ-028 SHALL place the following in a shared package (aes_pkg): KEY_W, NUM_RK=11, the Rcon table constant, and the state enum.
- REQ-029 SHALL use one sub-module, key_sched_step, that:
  - combinationally maps (prev_key, rcon) to next_key;
  - instantiates four of the codebase's existing sbox modules for SubWord.

Verification
- REQ-030 SHALL cover: start with key 000102030405060708090a0b0c0d0e0f -> expect rk1=d6aa74fdd2af72fadaa678f1d6ab76fe, rk10=13111d7fe3944a17f307a78b4d2b30c5 at T+11, and keys_ready at T+12.
- REQ-031 SHALL cover: start with key 2b7e151628aed2a6abf7158809cf4f3c -> expect rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; with KEY_STORE_EN, rd_idx=0..10 returns all 11 keys and rd_idx=15 returns 0.
- REQ-032 SHALL cover: second start at T+5 with a different key -> ignored, and the first key's sequence completes unchanged.
- REQ-033 SHALL cover: rst1 pulsed at T+6 -> all outputs 0 asynchronously, no rk_valid afterwards, and a restart produces a correct full sequence.
- REQ-034 SHALL cover: start in DONE -> keys_ready drops the next cycle and a new 11-key sequence follows at T+1..T+11.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key schedule constants, round constants and controller state type
package aes_pkg;
    localparam int KEY_W  = 128;
    localparam int NUM_RK = 11;
    // Entry 0 is never used: round key 0 is the cipher key itself
    localparam logic [NUM_RK-1:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;
endpackage

// File: rtl/key_sched_step.sv
// key_sched_step: one AES-128 key schedule round, previous round key plus Rcon to next round key
module key_sched_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key_i,
    input  logic [7:0]       rcon_i,
    output logic [KEY_W-1:0] next_key_o
);
    logic [31:0] rot, sub, w0, w1, w2, w3;
    assign rot = {prev_key_i[23:0], prev_key_i[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sb
        sbox u_sbox (.in_i(rot[8*i +: 8]), .out_o(sub[8*i +: 8]));
    end
    assign w0 = prev_key_i[127:96] ^ sub ^ {rcon_i, 24'h0};
    assign w1 = prev_key_i[95:64] ^ w0;
    assign w2 = prev_key_i[63:32] ^ w1;
    assign w3 = prev_key_i[31:0] ^ w2;
    assign next_key_o = {w0, w1, w2, w3};
endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box byte substitution (combinational lookup)
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign out_o = SBOX[in_i];
endmodule

// File: rtl/key_expansion.sv
// key_expansion: streams the 11 AES-128 round keys one per cycle; KEY_STORE_EN adds a readable 11-entry key store
module key_expansion #(
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst1,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_data,
    output logic             keys_ready,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);
    import aes_pkg::*;

    ks_state_e        state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [KEY_W-1:0] data_q, data_d, step_key;
    logic             accept, load;

    // A start is only taken when no expansion is running; load marks every cycle a new key appears
    assign accept = start && state_q != EXPAND;
    assign load   = accept || (state_q == EXPAND && idx_q != 4'd10);

    key_sched_step u_step (
        .prev_key_i(data_q),
        .rcon_i    (RCON[idx_d]),
        .next_key_o(step_key)
    );

    // Next state: restart on accepted start, finish after index 10, otherwise hold
    always_comb begin
        state_d = accept ? EXPAND : (state_q == EXPAND && idx_q == 4'd10) ? DONE : state_q;
        idx_d   = accept ? 4'd0 : load ? idx_q + 4'd1 : idx_q;
        data_d  = accept ? key_in : load ? step_key : data_q;
    end

    // State, index and current round key registers
    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign busy       = state_q == EXPAND;
    assign rk_valid   = busy;
    assign keys_ready = state_q == DONE;
    assign rk_idx     = idx_q;
    assign rk_data    = data_q;

`ifdef KEY_STORE_EN
    logic [KEY_W-1:0] store_q [NUM_RK];

    // Each round key is captured alongside the streamed copy, so it is readable while rk_valid shows it
    always_ff @(posedge clk or posedge rst1) begin
        if (rst1) begin
            for (int i = 0; i < NUM_RK; i++) store_q[i] <= '0;
        end else if (load) begin
            store_q[idx_d] <= data_d;
        end
    end

    assign rd_key = (rd_idx <= 4'd10) ? store_q[rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed stimulus against a cycle-level AES-128 key schedule model with literal pins
module tb_key_expansion;
    localparam logic [127:0] KA    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KA1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KA10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KB1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KB10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst1, start, busy, rk_valid, keys_ready;
    logic [127:0] key_in, rk_data, rd_key;
    logic [3:0]   rk_idx, rd_idx;
    int           n_vec = 0;
    int           n_bad = 0;
    logic [127:0] mk [11];
    logic [127:0] ms [11];

    always #5 clk = ~clk;

    key_expansion #(.KEY_W(128)) dut (
        .clk(clk), .rst1(rst1), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_data(rk_data),
        .keys_ready(keys_ready), .rd_idx(rd_idx), .rd_key(rd_key)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s, r;
        for (int v = 1; v < 256; v++) if (gmul(x, 8'(v)) == 8'h01) inv = 8'(v);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] nxt(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        t = {sb(w[3][23:16]), sb(w[3][15:8]), sb(w[3][7:0]), sb(w[3][31:24])} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle model: phase counts cycles since the accepted start; keys 0..10 appear in phases 1..11
    initial begin
        bit           act = 1'b0;
        int           ph = 0;
        logic         e_v;
        logic [3:0]   e_idx = 4'd0;
        logic [127:0] e_data = '0;
        logic [127:0] e_rd;
        logic [7:0]   rc;
        forever begin
            @(negedge clk);
            if (rst1) begin
                act = 1'b0;
                ph = 0;
                e_idx = 4'd0;
                e_data = '0;
                for (int i = 0; i < 11; i++) ms[i] = '0;
            end
            e_v = act && ph >= 1 && ph <= 11;
            if (e_v) begin
                e_idx = 4'(ph - 1);
                e_data = mk[ph-1];
                ms[ph-1] = e_data;
            end
            e_rd = '0;
`ifdef KEY_STORE_EN
            if (rd_idx <= 4'd10) e_rd = ms[rd_idx];
`endif
            chk("busy", 128'(busy), 128'(e_v));
            chk("rk_valid", 128'(rk_valid), 128'(e_v));
            chk("rk_idx", 128'(rk_idx), 128'(e_idx));
            chk("rk_data", rk_data, e_data);
            chk("keys_ready", 128'(keys_ready), 128'(act && ph >= 12));
            chk("rd_key", rd_key, e_rd);
            if (!rst1 && start && !e_v) begin
                act = 1'b1;
                ph = 1;
                mk[0] = key_in;
                rc = 8'h01;
                for (int r = 1; r < 11; r++) begin
                    mk[r] = nxt(mk[r-1], rc);
                    rc = xt(rc);
                end
            end else if (act && ph < 12) begin
                ph++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst1 = 1'b1;
        start = 1'b1;
        key_in = KB;
        rd_idx = 4'd0;
        tick();
        @(negedge clk);
        chk("reset rk_data", rk_data, '0);
        chk("reset busy", 128'(busy), '0);
        tick();
        // First cycle after reset release: start with key A is accepted here
        rst1 = 1'b0;
        key_in = KA;
        tick();
        start = 1'b0;
        key_in = 128'hdeadbeef_00000000_cafef00d_12345678;
        @(negedge clk);
        chk("A idx0", 128'(rk_idx), 128'd0);
        chk("A rk0", rk_data, KA);
        tick();
        @(negedge clk);
        chk("A rk1", rk_data, KA1);
        chk("model A rk1", mk[1], KA1);
        repeat (9) tick();
        @(negedge clk);
        chk("A idx10", 128'(rk_idx), 128'd10);
        chk("A rk10", rk_data, KA10);
        chk("model A rk10", mk[10], KA10);
        tick();
        @(negedge clk);
        chk("A keys_ready", 128'(keys_ready), 128'd1);
        chk("A rk10 held", rk_data, KA10);
        tick();
        // Start from DONE with key B; ignored starts at T+5 and at the index-10 cycle
        start = 1'b1;
        key_in = KB;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("B ready drop", 128'(keys_ready), 128'd0);
        chk("B rk0", rk_data, KB);
        repeat (4) tick();
        start = 1'b1;
        key_in = KA;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        @(negedge clk);
        chk("B rk10", rk_data, KB10);
        chk("model B rk1", mk[1], KB1);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("B keys_ready", 128'(keys_ready), 128'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            rd_idx = (i == 11) ? 4'd15 : 4'(i);
            @(negedge clk);
        end
        tick();
        rd_idx = 4'd0;
        // Reset pulse at T+6 of a running expansion, then a full restart with key B
        start = 1'b1;
        key_in = KA;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst1 = 1'b1;
        @(negedge clk);
        chk("rst busy", 128'(busy), '0);
        chk("rst rk_valid", 128'(rk_valid), '0);
        chk("rst rk_data", rk_data, '0);
        chk("rst rk_idx", 128'(rk_idx), '0);
        chk("rst keys_ready", 128'(keys_ready), '0);
        tick();
        rst1 = 1'b0;
        repeat (14) tick();
        start = 1'b1;
        key_in = KB;
        tick();
        start = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("restart rk10", rk_data, KB10);
        tick();
        @(negedge clk);
        chk("restart keys_ready", 128'(keys_ready), 128'd1);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
